xrek_verify_trace_ring: RTL and testbench

- Next-generation XREK verification and trace-integrity block.
- Logs executed steps into a parametrised ring buffer with a drain handshake.
- Performs masked comparison of expected vs. actual observations.
- Runs a per-step retry/rollback policy and reports each outcome as a one-cycle result pulse. Sits between the XREK step executor and the trace/recovery controller.

---
 rtl/xrek_verif_pkg.sv | 27 ++
 rtl/xrek_verify_trace_ring_if.sv | 42 ++++
 rtl/xrek_trace_ring.sv | 87 ++++++++
 rtl/xrek_verify_trace_ring.sv | 120 ++++++++++++
 tb/tb_xrek_verify_trace_ring.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xrek_verif_pkg.sv
// Shared types for the XREK verify/trace block: result codes, FSM states
// and the fixed id/timestamp widths carried in every trace entry.
package xrek_verif_pkg;

  localparam int TS_W = 32;
  localparam int ID_W = 32;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    RETRY    = 2'd1,
    ROLLBACK = 2'd2
  } result_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } vstate_t;

  // Masked observation compare: any differing bit that the mask enables.
  function automatic logic obs_mismatch(input logic [1023:0] exp_v,
                                        input logic [1023:0] act_v,
                                        input logic [1023:0] mask_v);
    return |((exp_v ^ act_v) & mask_v);
  endfunction

endpackage

// File: rtl/xrek_verify_trace_ring_if.sv
// Handshake bundle between the step executor / recovery controller (master)
// and the verify + trace block (slave).
interface xrek_verify_trace_ring_if #(
  parameter int OBS_W     = 256,
  parameter int PAYLOAD_W = 512,
  parameter int DEPTH     = 16,
  parameter int RETRY_W   = 8
);
  logic                         step_valid;
  logic                         step_ready;
  logic [31:0]                  step_id;
  logic [PAYLOAD_W-1:0]         step_payload;
  logic                         verify_valid;
  logic                         verify_ready;
  logic [OBS_W-1:0]             expected_obs;
  logic [OBS_W-1:0]             actual_obs;
  logic [OBS_W-1:0]             obs_mask;
  logic [RETRY_W-1:0]           max_retries;
  logic                         result_valid;
  logic [1:0]                   result_code;
  logic [RETRY_W-1:0]           retry_count;
  logic                         trace_rd_valid;
  logic                         trace_rd_ready;
  logic [64+PAYLOAD_W-1:0]      trace_rd_data;
  logic [$clog2(DEPTH+1)-1:0]   trace_count;
  logic                         trace_overflow;
  logic [31:0]                  timestamp;

  modport master (
    output step_valid, step_id, step_payload, verify_valid, expected_obs,
           actual_obs, obs_mask, max_retries, trace_rd_ready,
    input  step_ready, verify_ready, result_valid, result_code, retry_count,
           trace_rd_valid, trace_rd_data, trace_count, trace_overflow, timestamp
  );

  modport slave (
    input  step_valid, step_id, step_payload, verify_valid, expected_obs,
           actual_obs, obs_mask, max_retries, trace_rd_ready,
    output step_ready, verify_ready, result_valid, result_code, retry_count,
           trace_rd_valid, trace_rd_data, trace_count, trace_overflow, timestamp
  );
endinterface

// File: rtl/xrek_trace_ring.sv
// Trace ring FIFO: first-word-fall-through read, occupancy count, optional
// drop-oldest overwrite when full, and a sticky overflow flag.
module xrek_trace_ring #(
  parameter int WIDTH     = 576,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 1,
  parameter int CNT_W     = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == CNT_W'(0));
  assign w_pop   = !w_empty && i_rd_ready;
  assign w_push  = i_push_valid && o_push_ready;
  // A push into a full ring without a same-cycle pop evicts the oldest entry.
  assign w_drop  = w_push && w_full && !w_pop;

  // Accept policy: overwrite mode always accepts; otherwise a pop frees the slot.
  always_comb begin
    o_push_ready = 1'b1;
    if (OVERWRITE != 0) begin
      o_push_ready = 1'b1;
    end else begin
      o_push_ready = !w_full || i_rd_ready;
    end
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop || w_drop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop && !w_drop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_rd_valid = !w_empty;
  assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/xrek_verify_trace_ring.sv
// XREK verify/trace block: logs accepted steps into the trace ring and runs
// a masked compare with a per-step retry/rollback policy.
module xrek_verify_trace_ring
  import xrek_verif_pkg::*;
#(
  parameter int OBS_W     = 256,
  parameter int PAYLOAD_W = 512,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 1,
  parameter int RETRY_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  xrek_verify_trace_ring_if.slave bus
);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ID_W + TS_W + PAYLOAD_W;

  logic [TS_W-1:0]    r_ts;
  vstate_t            r_state;
  logic               r_mismatch;
  logic [RETRY_W-1:0] r_max;
  logic [RETRY_W-1:0] r_cnt;
  logic               r_res_valid;
  result_t            r_res_code;
  logic [RETRY_W-1:0] r_res_cnt;

  logic               w_step_accept;
  logic               w_mismatch;
  logic [ENTRY_W-1:0] w_entry;

  assign w_step_accept = bus.step_valid && bus.step_ready;
  assign w_mismatch    = obs_mismatch(1024'(bus.expected_obs), 1024'(bus.actual_obs),
                                      1024'(bus.obs_mask));
  assign w_entry       = {bus.step_id, r_ts, bus.step_payload};

  // Free-running timestamp; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  xrek_trace_ring #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE),
    .CNT_W     (CNT_W)
  ) u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (bus.step_valid),
    .o_push_ready (bus.step_ready),
    .i_push_data  (w_entry),
    .o_rd_valid   (bus.trace_rd_valid),
    .i_rd_ready   (bus.trace_rd_ready),
    .o_rd_data    (bus.trace_rd_data),
    .o_count      (bus.trace_count),
    .o_overflow   (bus.trace_overflow)
  );

  // Verify FSM, retry counter and registered result pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mismatch  <= 1'b0;
      r_max       <= '0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_code  <= PASS;
      r_res_cnt   <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.verify_valid) begin
            r_mismatch <= w_mismatch;
            r_max      <= bus.max_retries;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          r_res_valid <= 1'b1;
          r_state     <= REPORT;
          if (!r_mismatch) begin
            r_res_code <= PASS;
            r_res_cnt  <= r_cnt;
            r_cnt      <= '0;
          end else if (r_cnt < r_max) begin
            r_res_code <= RETRY;
            r_res_cnt  <= r_cnt + RETRY_W'(1);
            r_cnt      <= r_cnt + RETRY_W'(1);
          end else begin
            r_res_code <= ROLLBACK;
            r_res_cnt  <= r_cnt;
            r_cnt      <= '0;
          end
        end
        REPORT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // A newly accepted step starts a fresh retry budget, overriding any increment.
      if (w_step_accept) begin
        r_cnt <= '0;
      end
    end
  end

  assign bus.verify_ready = (r_state == IDLE);
  assign bus.result_valid = r_res_valid;
  assign bus.result_code  = r_res_code;
  assign bus.retry_count  = r_res_cnt;
  assign bus.timestamp    = r_ts;
endmodule

// File: tb/tb_xrek_verify_trace_ring.sv
// Scoreboard bench for xrek_verify_trace_ring: queue-based models of the
// retry policy and the trace ring, checked by independent monitors.
module tb_xrek_verify_trace_ring;
  import xrek_verif_pkg::*;

  localparam int OBS_W = 256;
  localparam int PW    = 512;
  localparam int DEPTH = 16;
  localparam int RW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xrek_verify_trace_ring_if #(.OBS_W(OBS_W), .PAYLOAD_W(PW), .DEPTH(DEPTH), .RETRY_W(RW)) bus_a ();
  xrek_verify_trace_ring_if #(.OBS_W(OBS_W), .PAYLOAD_W(PW), .DEPTH(DEPTH), .RETRY_W(RW)) bus_b ();

  xrek_verify_trace_ring #(.OBS_W(OBS_W), .PAYLOAD_W(PW), .DEPTH(DEPTH), .OVERWRITE(1), .RETRY_W(RW))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  xrek_verify_trace_ring #(.OBS_W(OBS_W), .PAYLOAD_W(PW), .DEPTH(DEPTH), .OVERWRITE(0), .RETRY_W(RW))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct { logic [1:0] code; logic [7:0] cnt; logic [31:0] cyc; } exp_res_t;
  typedef struct { logic [31:0] id; logic [31:0] ts; logic [PW-1:0] pl; } ent_t;

  exp_res_t    res_q[$];
  ent_t        ring_q[$];
  bit          m_ovf;
  int unsigned m_cnt;
  int          checks = 0;
  int          failures = 0;
  int          pop_mode = 0;
  logic [31:0] tb_ts;
  logic [31:0] next_id = 32'd1000;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [OBS_W-1:0] rnd_obs();
    logic [OBS_W-1:0] v;
    for (int i = 0; i < OBS_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    logic [PW-1:0] v;
    for (int i = 0; i < PW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Cycle reference: number of clock edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 32'd0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  always @(negedge rst_n) begin
    res_q.delete();
    ring_q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  end

  always @(posedge clk) begin
    #1;
    case (pop_mode)
      0:       bus_a.trace_rd_ready = 1'b0;
      1:       bus_a.trace_rd_ready = 1'b1;
      default: bus_a.trace_rd_ready = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Result monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_res_t r;
    if (rst_n && bus_a.result_valid) begin
      if (res_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result got code=%0d expected no pulse", bus_a.result_code);
      end else begin
        r = res_q.pop_front();
        chk("result_code", 64'(bus_a.result_code), 64'(r.code));
        chk("retry_count", 64'(bus_a.retry_count), 64'(r.cnt));
        chk("result_latency", 64'(tb_ts), 64'(r.cyc));
      end
    end
  end

  // Trace monitor: ring model as a bounded queue, oldest-first.
  always @(negedge clk) begin
    ent_t e;
    logic push, pop;
    if (rst_n) begin
      push = bus_a.step_valid && bus_a.step_ready;
      pop  = bus_a.trace_rd_valid && bus_a.trace_rd_ready;
      chk("trace_count", 64'(bus_a.trace_count), 64'(ring_q.size()));
      chk("trace_rd_valid", 64'(bus_a.trace_rd_valid), 64'(ring_q.size() != 0));
      chk("trace_overflow", 64'(bus_a.trace_overflow), 64'(m_ovf));
      chk("step_ready_ovw", 64'(bus_a.step_ready), 64'd1);
      chk("timestamp", 64'(bus_a.timestamp), 64'(tb_ts));
      if (pop) begin
        if (ring_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL pop_empty got rd_valid=1 expected 0");
        end else begin
          e = ring_q.pop_front();
          chk("rd_id", 64'(bus_a.trace_rd_data[64+PW-1 -: 32]), 64'(e.id));
          chk("rd_ts", 64'(bus_a.trace_rd_data[32+PW-1 -: 32]), 64'(e.ts));
          chk("rd_payload", 64'(bus_a.trace_rd_data[PW-1:0] == e.pl), 64'd1);
        end
      end
      if (push) begin
        if (ring_q.size() == DEPTH) begin
          void'(ring_q.pop_front());
          m_ovf = 1'b1;
        end
        e.id = bus_a.step_id; e.ts = tb_ts; e.pl = bus_a.step_payload;
        ring_q.push_back(e);
        m_cnt = 0;
      end
    end
  end

  task automatic step_a(input logic [31:0] id);
    @(posedge clk); #1;
    bus_a.step_valid = 1'b1; bus_a.step_id = id; bus_a.step_payload = rnd_pl();
    @(posedge clk); #1;
    bus_a.step_valid = 1'b0;
  endtask

  task automatic do_verify(input logic [OBS_W-1:0] e, input logic [OBS_W-1:0] a,
                           input logic [OBS_W-1:0] m, input logic [7:0] mx, input bit step_in_check);
    exp_res_t r;
    bit got = 1'b0;
    @(posedge clk); #1;
    bus_a.expected_obs = e; bus_a.actual_obs = a; bus_a.obs_mask = m;
    bus_a.max_retries = mx; bus_a.verify_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_a.verify_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("verify_accept", 64'(got), 64'd1);
    if (got) begin
      if (((e ^ a) & m) == '0) begin
        r.code = 2'd0; r.cnt = 8'(m_cnt); m_cnt = 0;
      end else if (m_cnt < mx) begin
        m_cnt = m_cnt + 1; r.code = 2'd1; r.cnt = 8'(m_cnt);
      end else begin
        r.code = 2'd2; r.cnt = 8'(m_cnt); m_cnt = 0;
      end
      r.cyc = tb_ts + 32'd2;
      res_q.push_back(r);
    end
    @(posedge clk); #1;
    bus_a.verify_valid = 1'b0;
    if (step_in_check) begin
      bus_a.step_valid = 1'b1; next_id++; bus_a.step_id = next_id; bus_a.step_payload = rnd_pl();
      @(posedge clk); #1;
      bus_a.step_valid = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic drain_a();
    pop_mode = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus_a.trace_count == '0) break;
    end
    chk("drain_empty", 64'(bus_a.trace_count), 64'd0);
    pop_mode = 0;
    @(posedge clk);
  endtask

  logic [OBS_W-1:0] va, vb, vm;
  logic [OBS_W-1:0] ones;

  initial begin
    ones = '1;
    bus_a.step_valid = 1'b0; bus_a.step_id = '0; bus_a.step_payload = '0;
    bus_a.verify_valid = 1'b0; bus_a.expected_obs = '0; bus_a.actual_obs = '0;
    bus_a.obs_mask = '0; bus_a.max_retries = '0;
    bus_b.step_valid = 1'b0; bus_b.step_id = '0; bus_b.step_payload = '0;
    bus_b.verify_valid = 1'b0; bus_b.expected_obs = '0; bus_b.actual_obs = '0;
    bus_b.obs_mask = '0; bus_b.max_retries = '0; bus_b.trace_rd_ready = 1'b0;
    #12;
    chk("rst_verify_ready", 64'(bus_a.verify_ready), 64'd1);
    chk("rst_step_ready", 64'(bus_a.step_ready), 64'd1);
    chk("rst_step_ready_b", 64'(bus_b.step_ready), 64'd1);
    chk("rst_result_valid", 64'(bus_a.result_valid), 64'd0);
    chk("rst_count", 64'(bus_a.trace_count), 64'd0);
    chk("rst_overflow", 64'(bus_a.trace_overflow), 64'd0);
    chk("rst_rd_valid", 64'(bus_a.trace_rd_valid), 64'd0);
    chk("rst_timestamp", 64'(bus_a.timestamp), 64'd0);
    chk("rst_rd_data", 64'(bus_a.trace_rd_data == '0), 64'd1);
    #10 rst_n = 1'b1;

    // Match with all-ones mask
    va = {32{8'hA5}};
    do_verify(va, va, ones, 8'd2, 1'b0);
    // Retry ladder: RETRY1, RETRY2, ROLLBACK2, RETRY1
    vb = ~va;
    repeat (4) do_verify(va, vb, ones, 8'd2, 1'b0);
    do_verify(va, va, ones, 8'd2, 1'b0);
    // Bit 7 difference: masked out, then compared
    vb = va; vb[7] = ~vb[7];
    vm = ones; vm[7] = 1'b0;
    do_verify(va, vb, vm, 8'd3, 1'b0);
    do_verify(va, vb, ones, 8'd3, 1'b0);
    // max_retries = 0 after a fresh step
    next_id++; step_a(next_id);
    do_verify(va, vb, ones, 8'd0, 1'b0);
    // Step between retries restarts the count
    do_verify(va, vb, ones, 8'd5, 1'b0);
    next_id++; step_a(next_id);
    do_verify(va, vb, ones, 8'd5, 1'b0);
    // Step during CHECK: reported count unaffected, next starts from 1
    do_verify(va, vb, ones, 8'd5, 1'b1);
    do_verify(va, vb, ones, 8'd5, 1'b0);
    // All-zero mask
    do_verify(va, ~va, '0, 8'd1, 1'b0);

    // Overwrite: 18 pushes into a 16-deep ring, then drain ids 3..18
    drain_a();
    for (int i = 1; i <= 18; i++) step_a(32'(i));
    @(negedge clk);
    chk("ovw_count", 64'(bus_a.trace_count), 64'd16);
    chk("ovw_overflow", 64'(bus_a.trace_overflow), 64'd1);
    chk("ovw_head_id", 64'(bus_a.trace_rd_data[64+PW-1 -: 32]), 64'd3);
    drain_a();

    // Backpressure ring: fill, blocked push, then push alongside a pop
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      bus_b.step_valid = 1'b1; bus_b.step_id = 32'(i);
    end
    @(posedge clk); #1;
    bus_b.step_id = 32'd17;
    @(negedge clk);
    chk("bp_count", 64'(bus_b.trace_count), 64'd16);
    chk("bp_step_ready", 64'(bus_b.step_ready), 64'd0);
    @(posedge clk); #1;
    chk("bp_head_blocked", 64'(bus_b.trace_rd_data[64+PW-1 -: 32]), 64'd1);
    bus_b.trace_rd_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_with_pop", 64'(bus_b.step_ready), 64'd1);
    @(posedge clk); #1;
    bus_b.step_valid = 1'b0; bus_b.trace_rd_ready = 1'b0;
    @(negedge clk);
    chk("bp_count_after", 64'(bus_b.trace_count), 64'd16);
    chk("bp_overflow", 64'(bus_b.trace_overflow), 64'd0);
    chk("bp_head_after", 64'(bus_b.trace_rd_data[64+PW-1 -: 32]), 64'd2);

    // Randomized traffic
    pop_mode = 2;
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        next_id++; step_a(next_id);
      end else begin
        va = rnd_obs();
        case ($urandom_range(0, 2))
          0:       vb = va;
          1:       begin vb = va; vb[$urandom_range(0, OBS_W-1)] ^= 1'b1; end
          default: vb = rnd_obs();
        endcase
        case ($urandom_range(0, 2))
          0:       vm = ones;
          1:       vm = rnd_obs();
          default: vm = '0;
        endcase
        do_verify(va, vb, vm, 8'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
      end
    end
    drain_a();

    // Async reset while the FSM is in CHECK
    next_id++; step_a(next_id);
    @(posedge clk); #1;
    bus_a.expected_obs = '0; bus_a.actual_obs = ones; bus_a.obs_mask = ones;
    bus_a.max_retries = 8'd3; bus_a.verify_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.verify_valid = 1'b0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_pulse", 64'(bus_a.result_valid), 64'd0);
    end
    chk("rst_mid_count", 64'(bus_a.trace_count), 64'd0);
    chk("rst_mid_verify_ready", 64'(bus_a.verify_ready), 64'd1);
    chk("rst_mid_overflow", 64'(bus_a.trace_overflow), 64'd0);
    do_verify('0, ones, ones, 8'd3, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(res_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
